tap_controller: RTL and testbench

- IEEE 1149.1-style Test Access Port controller that sequences the boundary-scan chain and owns the instruction path.
- Contains the 16-state TAP FSM, a 2-bit instruction shift/update register, a 1-bit bypass register and the TDO select mux.
- Generates the capture, shift and update enables plus bs_en for the external boundary-scan cell chain.
- Sits between the chip JTAG pins and the boundary-scan register.

---
 rtl/tap_controller.sv | 147 ++++++++++++++
 tb/tb_tap_controller.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/tap_controller.sv
// JTAG test access port controller: 16-state TAP FSM, 2-bit instruction register,
// bypass bit and TDO mux, plus capture/shift/update strobes for the boundary-scan chain.
//
// state | meaning
// ------+-------------------------------------------------------------
// TLR   | Test-Logic-Reset, instruction forced to BYPASS every TCK
// RTI   | Run-Test/Idle
// SELDR | Select-DR-Scan
// CAPDR | Capture-DR, BSR capture or bypass bit cleared
// SHDR  | Shift-DR, selected data register shifts TDI toward TDO
// EX1DR | Exit1-DR
// PAUDR | Pause-DR, data registers hold
// EX2DR | Exit2-DR, may resume shifting without recapture
// UPDDR | Update-DR, BSR update strobe
// SELIR | Select-IR-Scan
// CAPIR | Capture-IR, shift stage loaded with IR_CAPTURE
// SHIR  | Shift-IR, LSB of the shift stage drives TDO
// EX1IR | Exit1-IR
// PAUIR | Pause-IR, shift stage holds
// EX2IR | Exit2-IR
// UPDIR | Update-IR, shift stage copied into the active instruction
module tap_controller #(
    parameter int             IR_W       = 2,
    parameter logic [IR_W-1:0] IR_CAPTURE = 2'b01,
    parameter logic [IR_W-1:0] OP_EXTEST  = 2'b00,
    parameter logic [IR_W-1:0] OP_SAMPLE  = 2'b01,
    parameter logic [IR_W-1:0] OP_BYPASS  = 2'b11
) (
    input  logic            TCK,
    input  logic            TRST_N,
    input  logic            TMS,
    input  logic            TDI,
    input  logic            bsr_tdo,
    output logic            bsr_tdi,
    output logic            bsr_capture,
    output logic            bsr_shift,
    output logic            bsr_update,
    output logic            bs_en,
    output logic            TDO,
    output logic            tdo_en,
    output logic [IR_W-1:0] inst,
    output logic [3:0]      state
);

    localparam logic [3:0] TLR   = 4'hF;
    localparam logic [3:0] RTI   = 4'hC;
    localparam logic [3:0] SELDR = 4'h7;
    localparam logic [3:0] CAPDR = 4'h6;
    localparam logic [3:0] SHDR  = 4'h2;
    localparam logic [3:0] EX1DR = 4'h1;
    localparam logic [3:0] PAUDR = 4'h3;
    localparam logic [3:0] EX2DR = 4'h0;
    localparam logic [3:0] UPDDR = 4'h5;
    localparam logic [3:0] SELIR = 4'h4;
    localparam logic [3:0] CAPIR = 4'hE;
    localparam logic [3:0] SHIR  = 4'hA;
    localparam logic [3:0] EX1IR = 4'h9;
    localparam logic [3:0] PAUIR = 4'hB;
    localparam logic [3:0] EX2IR = 4'h8;
    localparam logic [3:0] UPDIR = 4'hD;

    logic [3:0]      state_nxt;
    logic [IR_W-1:0] ir_q;
    logic [IR_W-1:0] ir_sr;
    logic            byp;
    logic            sel_bsr;

    always_comb begin
        state_nxt = state;
        case (state)
            TLR:   state_nxt = TMS ? TLR   : RTI;
            RTI:   state_nxt = TMS ? SELDR : RTI;
            SELDR: state_nxt = TMS ? SELIR : CAPDR;
            CAPDR: state_nxt = TMS ? EX1DR : SHDR;
            SHDR:  state_nxt = TMS ? EX1DR : SHDR;
            EX1DR: state_nxt = TMS ? UPDDR : PAUDR;
            PAUDR: state_nxt = TMS ? EX2DR : PAUDR;
            EX2DR: state_nxt = TMS ? UPDDR : SHDR;
            UPDDR: state_nxt = TMS ? SELDR : RTI;
            SELIR: state_nxt = TMS ? TLR   : CAPIR;
            CAPIR: state_nxt = TMS ? EX1IR : SHIR;
            SHIR:  state_nxt = TMS ? EX1IR : SHIR;
            EX1IR: state_nxt = TMS ? UPDIR : PAUIR;
            PAUIR: state_nxt = TMS ? EX2IR : PAUIR;
            EX2IR: state_nxt = TMS ? UPDIR : SHIR;
            UPDIR: state_nxt = TMS ? SELDR : RTI;
            default: state_nxt = TLR;
        endcase
    end

    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            state <= TLR;
        end else begin
            state <= state_nxt;
        end
    end

    // Instruction path: shift stage and the active (updated) instruction.
    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            ir_sr <= IR_CAPTURE;
            ir_q  <= OP_BYPASS;
        end else begin
            case (state)
                TLR:     ir_q  <= OP_BYPASS;
                CAPIR:   ir_sr <= IR_CAPTURE;
                SHIR:    ir_sr <= {TDI, ir_sr[IR_W-1:1]};
                UPDIR:   ir_q  <= ir_sr;
                default: ;
            endcase
        end
    end

    // Unrecognised opcodes fall through to bypass.
    assign sel_bsr = (ir_q == OP_EXTEST) || (ir_q == OP_SAMPLE);

    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            byp <= 1'b0;
        end else if (!sel_bsr) begin
            if (state == CAPDR) begin
                byp <= 1'b0;
            end else if (state == SHDR) begin
                byp <= TDI;
            end
        end
    end

    assign bsr_capture = (state == CAPDR) && sel_bsr;
    assign bsr_shift   = (state == SHDR)  && sel_bsr;
    assign bsr_update  = (state == UPDDR) && sel_bsr;
    assign bsr_tdi     = TDI;
    assign bs_en       = (ir_q == OP_EXTEST);
    assign inst        = ir_q;
    assign tdo_en      = (state == SHDR) || (state == SHIR);

    always_comb begin
        TDO = 1'b0;
        if (state == SHIR) begin
            TDO = ir_sr[0];
        end else if (state == SHDR) begin
            TDO = sel_bsr ? bsr_tdo : byp;
        end
    end

endmodule

// File: tb/tb_tap_controller.sv
// Directed bench for tap_controller: stimulus queues expected observations per TCK,
// a monitor compares them at the falling edge.
module tb_tap_controller;

    logic       TCK = 1'b0;
    logic       TRST_N, TMS, TDI, bsr_tdo;
    logic       bsr_tdi, bsr_capture, bsr_shift, bsr_update, bs_en, TDO, tdo_en;
    logic [1:0] inst;
    logic [3:0] state;

    tap_controller dut (
        .TCK(TCK), .TRST_N(TRST_N), .TMS(TMS), .TDI(TDI), .bsr_tdo(bsr_tdo),
        .bsr_tdi(bsr_tdi), .bsr_capture(bsr_capture), .bsr_shift(bsr_shift),
        .bsr_update(bsr_update), .bs_en(bs_en), .TDO(TDO), .tdo_en(tdo_en),
        .inst(inst), .state(state)
    );

    always #5 TCK = ~TCK;

    int cyc = 0;
    always @(posedge TCK) cyc <= cyc + 1;

    // observation vector: state | inst | bs_en tdo_en TDO cap shift upd
    logic [11:0] obs;
    assign obs = {state, inst, bs_en, tdo_en, TDO, bsr_capture, bsr_shift, bsr_update};

    localparam logic [11:0] M_ST    = 12'hF00;
    localparam logic [11:0] M_INST  = 12'h0C0;
    localparam logic [11:0] M_BSEN  = 12'h020;
    localparam logic [11:0] M_TDOEN = 12'h010;
    localparam logic [11:0] M_TDO   = 12'h008;
    localparam logic [11:0] M_CAP   = 12'h004;
    localparam logic [11:0] M_SH    = 12'h002;
    localparam logic [11:0] M_UPD   = 12'h001;
    localparam logic [11:0] M_ALL   = 12'hFFF;

    typedef struct {
        int          cyc;
        string       name;
        logic [11:0] mask;
        logic [11:0] val;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [11:0] mk(input logic [3:0] st, input logic [1:0] in,
                                       input logic [5:0] flags);
        return {st, in, flags};
    endfunction

    task automatic chk(input string name, input logic [11:0] mask, input logic [11:0] val);
        exp_t e;
        e.cyc  = cyc;
        e.name = name;
        e.mask = mask;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic step(input logic tms, input logic tdi);
        TMS = tms;
        TDI = tdi;
        @(posedge TCK);
        #1;
    endtask

    initial begin
        forever begin
            @(negedge TCK);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                mon_e = sb.pop_front();
                n_tests++;
                if ((obs & mon_e.mask) !== (mon_e.val & mon_e.mask)) begin
                    n_fail++;
                    $display("FAIL %s: got %h want %h (mask %h) at cycle %0d",
                             mon_e.name, obs & mon_e.mask, mon_e.val & mon_e.mask,
                             mon_e.mask, cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, %0d checks pending", sb.size());
        $fatal(1, "timeout");
    end

    int          plen[16];
    logic [6:0]  pbits[16];
    logic [3:0]  pst[16];
    logic [3:0]  pat;
    logic [3:0]  exp_tdo;

    initial begin
        plen[0]  = 1; pbits[0]  = 7'd0;  pst[0]  = 4'hC;
        plen[1]  = 2; pbits[1]  = 7'd2;  pst[1]  = 4'h7;
        plen[2]  = 3; pbits[2]  = 7'd2;  pst[2]  = 4'h6;
        plen[3]  = 4; pbits[3]  = 7'd2;  pst[3]  = 4'h2;
        plen[4]  = 4; pbits[4]  = 7'd10; pst[4]  = 4'h1;
        plen[5]  = 5; pbits[5]  = 7'd10; pst[5]  = 4'h3;
        plen[6]  = 6; pbits[6]  = 7'd42; pst[6]  = 4'h0;
        plen[7]  = 5; pbits[7]  = 7'd26; pst[7]  = 4'h5;
        plen[8]  = 3; pbits[8]  = 7'd6;  pst[8]  = 4'h4;
        plen[9]  = 4; pbits[9]  = 7'd6;  pst[9]  = 4'hE;
        plen[10] = 5; pbits[10] = 7'd6;  pst[10] = 4'hA;
        plen[11] = 5; pbits[11] = 7'd22; pst[11] = 4'h9;
        plen[12] = 6; pbits[12] = 7'd22; pst[12] = 4'hB;
        plen[13] = 7; pbits[13] = 7'd86; pst[13] = 4'h8;
        plen[14] = 6; pbits[14] = 7'd54; pst[14] = 4'hD;
        plen[15] = 0; pbits[15] = 7'd0;  pst[15] = 4'hF;

        TRST_N = 1'b0; TMS = 1'b1; TDI = 1'b0; bsr_tdo = 1'b0;
        @(posedge TCK); #1;
        chk("reset_hold", M_ALL, mk(4'hF, 2'b11, 6'b000000));
        TRST_N = 1'b1;

        // 1: asynchronous reset in the middle of Shift-IR
        step(0, 0); step(1, 0); step(1, 0); step(0, 0); step(0, 1);
        chk("t1_in_shir", M_ST | M_TDOEN, mk(4'hA, 2'b00, 6'b010000));
        step(0, 1);
        TRST_N = 1'b0;
        #1;
        chk("t1_async_rst", M_ST | M_INST | M_BSEN | M_TDOEN | M_TDO,
            mk(4'hF, 2'b11, 6'b000000));
        @(posedge TCK); #1;
        TRST_N = 1'b1;
        chk("t1_released", M_ALL, mk(4'hF, 2'b11, 6'b000000));
        step(0, 0);
        chk("t1_to_rti", M_ST | M_INST, mk(4'hC, 2'b11, 6'b000000));

        // 2: five TMS=1 reach TLR from every state
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 5; k++) step(1, 0);
            for (int k = 0; k < plen[i]; k++) step(pbits[i][k], 0);
            chk($sformatf("t2_reach_%0d", i), M_ST, mk(pst[i], 2'b00, 6'b0));
            for (int k = 0; k < 5; k++) step(1, 0);
            chk($sformatf("t2_tlr_from_%0d", i), M_ST, mk(4'hF, 2'b00, 6'b0));
        end

        // 3: load EXTEST through the IR
        step(0, 0); step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        chk("t3_ir_bit0", M_ST | M_TDOEN | M_TDO, mk(4'hA, 2'b00, 6'b011000));
        step(0, 0);
        chk("t3_ir_bit1", M_ST | M_TDOEN | M_TDO, mk(4'hA, 2'b00, 6'b010000));
        step(1, 0);
        step(1, 0);
        chk("t3_updir_pre", M_ST | M_INST | M_BSEN, mk(4'hD, 2'b11, 6'b000000));
        step(0, 0);
        chk("t3_extest", M_ST | M_INST | M_BSEN | M_TDOEN, mk(4'hC, 2'b00, 6'b100000));

        // 5: SAMPLE (01 shifted LSB first as 1,0)
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        step(0, 1); step(1, 0); step(1, 0); step(0, 0);
        chk("t5_sample", M_INST | M_BSEN, mk(4'h0, 2'b01, 6'b000000));
        step(1, 0); step(0, 0);
        chk("t5_capdr", M_ST | M_BSEN | M_CAP | M_SH | M_UPD, mk(4'h6, 2'b00, 6'b000100));
        step(0, 0);
        bsr_tdo = 1'b1; #1;
        chk("t5_shdr_hi", M_ALL, mk(4'h2, 2'b01, 6'b011010));
        step(0, 1);
        bsr_tdo = 1'b0; #1;
        chk("t5_shdr_lo", M_ALL, mk(4'h2, 2'b01, 6'b010010));
        step(1, 0);
        chk("t5_ex1dr", M_ST | M_CAP | M_SH | M_UPD, mk(4'h1, 2'b00, 6'b000000));
        step(1, 0);
        chk("t5_upddr", M_ST | M_BSEN | M_CAP | M_SH | M_UPD, mk(4'h5, 2'b00, 6'b000001));
        step(0, 0);
        chk("t5_rti", M_ST | M_BSEN | M_UPD, mk(4'hC, 2'b00, 6'b000000));

        // 4: bypass after TLR restores the instruction
        for (int k = 0; k < 5; k++) step(1, 0);
        step(0, 0);
        chk("t4_inst_bypass", M_ST | M_INST | M_BSEN, mk(4'hC, 2'b11, 6'b000000));
        step(1, 0); step(0, 0);
        chk("t4_capdr", M_ST | M_CAP, mk(4'h6, 2'b00, 6'b000000));
        step(0, 0);
        pat = 4'b1101;      // TDI bits 1,0,1,1 in order k=0..3
        exp_tdo = 4'b1010;  // TDO bits 0,1,0,1
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t4_byp_bit%0d", k), M_ST | M_TDOEN | M_TDO | M_SH,
                mk(4'h2, 2'b00, {1'b0, 1'b1, exp_tdo[k], 3'b000}));
            step(k == 3, pat[k]);
        end
        chk("t4_ex1dr", M_ST | M_TDO, mk(4'h1, 2'b00, 6'b0));
        step(1, 0); step(0, 0);

        // 6: pause holds the bypass bit and resumes without recapture
        step(1, 0); step(0, 0); step(0, 1); step(1, 1);
        step(0, 0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t6_pause%0d", k), M_ST | M_SH | M_CAP | M_TDO | M_TDOEN,
                mk(4'h3, 2'b00, 6'b000000));
            step(k == 2, 0);
        end
        chk("t6_ex2dr", M_ST | M_CAP, mk(4'h0, 2'b00, 6'b000000));
        step(0, 0);
        chk("t6_resume", M_ST | M_CAP | M_TDO | M_TDOEN, mk(4'h2, 2'b00, 6'b011000));
        step(0, 0);
        chk("t6_shift_on", M_ST | M_TDO, mk(4'h2, 2'b00, 6'b000000));
        for (int k = 0; k < 5; k++) step(1, 0);

        @(negedge TCK);
        @(negedge TCK);
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
